// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-master I2C controller moving one 32-bit payload per command.
//   clk, rst_n          : clock, synchronous active-low reset
//   cmd_valid/rw/addr/wdata : command request, taken only while idle
//   busy, done, nack    : transaction status; done is a one-cycle pulse, nack valid with it
//   rdata               : read payload, valid from done until the next command
//   scl_oe, sda_oe      : open-drain pull-downs (1 = drive low)
//   sda_in              : sampled SDA bus level
module i2c_master_ctrl #(
   parameter int unsigned CLK_DIV = 250
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   input  logic        cmd_rw,
   input  logic [6:0]  cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        busy,
   output logic        done,
   output logic        nack,
   output logic [31:0] rdata,
   output logic        scl_oe,
   output logic        sda_oe,
   input  logic        sda_in
);
   typedef enum logic [3:0] {IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK, STOP, DONE} state_t;
   localparam logic [15:0] QMAX = 16'(CLK_DIV - 1);
   state_t      state_q, state_d;
   logic [15:0] qcnt_q, qcnt_d;
   logic [1:0]  phase_q, phase_d;
   logic [2:0]  bit_q, bit_d;
   logic [1:0]  byte_q, byte_d;
   logic [39:0] tx_q, tx_d;
   logic        rw_q, rw_d;
   logic        nack_q, nack_d;
   logic [31:0] rdata_q, rdata_d;
   logic        tick, bit_end, sample;
   always_comb begin
      tick    = qcnt_q == QMAX;
      bit_end = tick && phase_q == 2'd3;
      sample  = phase_q == 2'd3 && qcnt_q == 16'd0;
      state_d = state_q;
      qcnt_d  = tick ? 16'd0 : qcnt_q + 16'd1;
      phase_d = tick ? phase_q + 2'd1 : phase_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      tx_d    = tx_q;
      rw_d    = rw_q;
      nack_d  = nack_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            qcnt_d  = 16'd0;
            phase_d = 2'd0;
            if (cmd_valid) begin
               state_d = START;
               // address byte and payload form one MSB-first transmit stream
               tx_d    = {cmd_addr, cmd_rw, cmd_wdata};
               rw_d    = cmd_rw;
               nack_d  = 1'b0;
               bit_d   = 3'd0;
               byte_d  = 2'd0;
            end
         end
         START: if (bit_end) state_d = ADDR;
         ADDR, WDATA: if (bit_end) begin
            tx_d  = tx_q << 1;
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = state_q == ADDR ? ADDR_ACK : WACK;
         end
         ADDR_ACK: begin
            if (sample && sda_in) nack_d = 1'b1;
            if (bit_end) state_d = nack_q ? STOP : rw_q ? RDATA : WDATA;
         end
         WACK: begin
            if (sample && sda_in) nack_d = 1'b1;
            if (bit_end) begin
               state_d = (nack_q || byte_q == 2'd3) ? STOP : WDATA;
               byte_d  = byte_q + 2'd1;
            end
         end
         RDATA: begin
            if (sample) rdata_d = {rdata_q[30:0], sda_in};
            if (bit_end) begin
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = RACK;
            end
         end
         RACK: if (bit_end) begin
            state_d = byte_q == 2'd3 ? STOP : RDATA;
            byte_d  = byte_q + 2'd1;
         end
         STOP: if (bit_end) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         qcnt_q  <= '0;
         phase_q <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         tx_q    <= '0;
         rw_q    <= 1'b0;
         nack_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         qcnt_q  <= qcnt_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         tx_q    <= tx_d;
         rw_q    <= rw_d;
         nack_q  <= nack_d;
         rdata_q <= rdata_d;
      end
   end
   assign busy  = state_q != IDLE && state_q != DONE;
   assign done  = state_q == DONE;
   assign nack  = nack_q;
   assign rdata = rdata_q;
   // SCL is low for the first half of every bit outside START/IDLE/DONE
   assign scl_oe = busy && state_q != START && !phase_q[1];
   assign sda_oe = state_q == START ? phase_q[1] :
                   (state_q == ADDR || state_q == WDATA) ? ~tx_q[39] :
                   state_q == RACK ? byte_q != 2'd3 :
                   state_q == STOP ? phase_q != 2'd3 : 1'b0;
endmodule

// File: doc/i2c_master_ctrl.md
I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 250, meaning clk cycles per quarter SCL period (legal range 2..65535); one SCL bit = 4*CLK_DIV clk cycles.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port cmd_valid, input, 1 bit: transaction request, sampled only when busy=0.
REQ-005 SHALL have port cmd_rw, input, 1 bit: 0 = write 32-bit payload, 1 = read 32-bit payload.
REQ-006 SHALL have port cmd_addr, input, 7 bits: target device address.
REQ-007 SHALL have port cmd_wdata, input, 32 bits: write payload, sent MSB first.
REQ-008 SHALL have port busy, output, 1 bit: high from command acceptance through end of STOP.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse at transaction end.
REQ-010 SHALL have port nack, output, 1 bit: valid with done; 1 = slave failed to acknowledge.
REQ-011 SHALL have port rdata, output, 32 bits: read payload, valid from done until next acceptance.
REQ-012 SHALL have port scl_oe, output, 1 bit: 1 pulls SCL low, 0 releases it (open-drain).
REQ-013 SHALL have port sda_oe, output, 1 bit: 1 pulls SDA low, 0 releases it (open-drain).
REQ-014 SHALL have port sda_in, input, 1 bit: sampled bus SDA level.

Function
REQ-015 SHALL accept a command when cmd_valid=1 and busy=0, latching cmd_rw, cmd_addr and cmd_wdata; busy rises the next cycle.
REQ-016 SHALL ignore cmd_valid while busy=1; no queuing.
REQ-017 SHALL use the states IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK, STOP, DONE.
REQ-018 SHALL use a quarter-phase counter: in each bit, phases 0-1 hold SCL low and phases 2-3 release SCL; SDA changes only at the start of phase 0; sda_in is sampled at the start of phase 3.
REQ-019 SHALL generate START from IDLE with both lines released for 2 quarters, then SDA low for 2 quarters with SCL released, then SCL low.
REQ-020 SHALL send {cmd_addr, cmd_rw} (8 bits, MSB first) in ADDR, then release SDA for one bit in ADDR_ACK.
REQ-021 SHALL treat sda_in=1 sampled in ADDR_ACK or WACK as NACK: go to STOP and set nack=1 for the done pulse.
REQ-022 SHALL, for a write, send 4 bytes in WDATA, wdata[31:24] first, with a WACK bit after each byte.
REQ-023 SHALL, for a read, shift 4 bytes into rdata MSB first in RDATA; in RACK it drives ACK (sda_oe=1) after bytes 1-3 and NACK (sda_oe=0) after byte 4.
REQ-024 SHALL generate STOP as one bit period: SDA low with SCL low for 2 quarters, then SCL released for 1 quarter, then SDA released for 1 quarter.
REQ-025 SHALL enter DONE for exactly one cycle after STOP, asserting done, then return to IDLE; busy falls in the same cycle that done is asserted.
REQ-026 SHALL take a full transaction with no NACK of 1+9+36+1 = 47 bit periods (47*4*CLK_DIV clk cycles) from busy rising to done.
REQ-027 SHALL keep nack=0 and rdata unchanged for a write that completes without NACK.
REQ-028 SHALL not support clock stretching; SCL timing is derived only from the counter.

Reset
REQ-029 SHALL, while rst_n=0 at a clk edge, set state=IDLE, scl_oe=0, sda_oe=0, busy=0, done=0, nack=0, rdata=0, and clear all counters.
REQ-030 SHALL, on reset mid-transaction, release both lines on the next edge, emit no done pulse, and generate no STOP.

Verification
REQ-031 Bench SHALL check a write: CLK_DIV=4, addr 0x2A, wdata 0xCAFEF00D, slave ACKs all -> bus shows byte 0x54 then CA FE F0 0D; done at 752 clks after busy; nack=0.
REQ-032 Bench SHALL check a read: addr 0x2A, slave returns 0xCCAAF0F0 -> address byte 0x55; rdata=0xCCAAF0F0 at done; master ACKs 3 bytes and NACKs the 4th.
REQ-033 Bench SHALL check an address NACK: addr 0x11, SDA left high -> STOP follows ADDR_ACK directly, done with nack=1, no data bits are sent.
REQ-034 Bench SHALL check a write-byte NACK: slave NACKs byte 2 -> STOP follows that WACK, nack=1, and bytes 3-4 are never driven.
REQ-035 Bench SHALL check a command during busy: cmd_valid pulsed mid-transfer -> it is ignored and no second transaction follows.
REQ-036 Bench SHALL check reset mid-transfer: rst_n low during a WDATA bit -> scl_oe=sda_oe=0 next cycle, busy=0, no done; a new command afterwards completes normally.
